weight_streamer: RTL and testbench
==================================

# weight_streamer

Parametrised weight-row streamer for forward propagation: holds the weight matrices of NUM_LAYERS layers in one row-organised store and, on a one-cycle start for a selected layer, streams that layer's rows (LANES words per row) to the MAC array, one row per accepted beat. It is the generalised successor of the fixed two-layer weight source. It adds a run-time layer table, a row write port for loading, valid/ready backpressure, done/error reporting and abort.

## Interface
- DATA_W, 32, bits per weight word
- LANES, 128, weight words per row (MAC array width)
- DEPTH, 912, total rows in store (784 + 128 for the default two-layer net)
- NUM_LAYERS, 2, entries in layer table
- AW, $clog2(DEPTH), derived row-address width
- LW, $clog2(NUM_LAYERS) min 1, derived layer-index width

- clka  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  write layer-table entry
- cfg_layer  in  LW  entry index
- cfg_base  in  AW  first row of layer
- cfg_len  in  AW+1  row count of layer (0..DEPTH)
- wr_en  in  1  write one row into store
- wr_addr  in  AW  row address
- wr_data  in  LANES x DATA_W  row contents
- start  in  1  one-cycle stream request
- start_layer  in  LW  layer to stream
- abort  in  1  terminate current stream
- out_valid  out  1  out_data holds a row
- out_ready  in  1  consumer accepts row
- out_data  out  LANES x DATA_W  row words; all zero when out_valid=0
- out_row  out  AW  row index within layer (0-based)
- out_last  out  1  current row is the layer's last
- busy  out  1  stream in progress
- done  out  1  one-cycle pulse after last row accepted
- err  out  1  one-cycle pulse on rejected request

## Operation
- Reset: out_valid, out_data, out_row, out_last, busy, done, err = 0; state IDLE; all table entries base=0, len=0. Row store not cleared.
- States: IDLE, STREAM.
- IDLE + start, valid layer, len>0: load row base into output register, out_valid=1, out_row=0, out_last=(len==1), busy=1 -> STREAM.
- IDLE + start, len=0: no beats; done pulses next cycle; stay IDLE.
- start_layer >= NUM_LAYERS, or start while busy: ignored, err pulses.
- STREAM: at edge with out_valid && out_ready: if out_last -> out_valid=0, out_data=0, out_last=0, busy=0, done=1, -> IDLE; else load next row, out_row+1, out_last updated. If out_ready=0, out_data/out_row/out_last held stable.
- Row address = (base + out_row) mod DEPTH (wrap past DEPTH-1 to 0).
- abort (any state): at edge, out_valid=0, out_data=0, busy=0, no done, -> IDLE. abort with start same cycle: abort wins, start dropped, no err.
- cfg_we while busy: ignored, err pulses. cfg_we in IDLE updates entry at edge; start in same cycle uses old entry.
- wr_en allowed any time; row fetch at the same edge from wr_addr returns old contents (read-before-write).
- err with multiple causes in one cycle: single pulse.

## Timing
- start sampled at edge k -> first row visible after edge k (latency 1).
- With out_ready held 1: rows on consecutive cycles, len beats after edges k..k+len-1; done high after edge k+len; busy low after edge k+len.
- Back-to-back: start may be sampled in the cycle done is high (busy already 0).
- done, err: exactly one cycle each.
- No combinational path from out_ready to out_valid/out_data.

## Structure
- Package weight_streamer_pkg: default DATA_W/LANES/DEPTH/NUM_LAYERS, state enum typedef (IDLE, STREAM), layer_cfg_t struct {base, len}, row_t packed type LANES x DATA_W.
- Sub-module weight_row_ram: DEPTH x row_t store, one write port, one read port, read-before-write; no reset.
- Top holds layer table, FSM, row counter, output register.

## Test plan
- Reset mid-stream (row 5 of 784): all outputs 0, busy 0; table back to len 0; subsequent start -> done only, no beats.
- Layer 0 base 0 len 784, ROW r word i = 128r+i, out_ready=1: 784 beats, out_data[20] at row 3 = 404, out_last on row 783, done one cycle later, out_data then 0.
- Layer 1 base 784 len 128 with out_ready toggled 1/0 every cycle: 128 beats, data stable while stalled, total 255 cycles to done.
- Layer base 900 len 20, DEPTH 912: row 12 reads store row 0; out_last at out_row 19.
- start while busy, start_layer=2, cfg_we while busy: each err pulse, stream unaffected.
- abort at row 10 with start same cycle: out_valid 0 next cycle, no done, no err; wr_en to next row at fetch edge returns old data.

Source files
------------

// File: rtl/weight_streamer_pkg.sv
// Shared types and default sizing for the weight-row streamer.
// Defaults describe the two-layer 784/128 network feeding a 128-lane MAC array.
package weight_streamer_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_LANES      = 128;
    localparam int DEF_DEPTH      = 912;
    localparam int DEF_NUM_LAYERS = 2;
    localparam int DEF_AW         = $clog2(DEF_DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_t;

    typedef logic [DEF_LANES-1:0][DEF_DATA_W-1:0] row_t;

    typedef struct packed {
        logic [DEF_AW-1:0] base;
        logic [DEF_AW:0]   len;
    } layer_cfg_t;

    // Layer-index width; a single-entry table still needs one select bit.
    function automatic int lw_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weight_streamer_if.sv
// Row stream toward the MAC array: valid/ready handshake carrying one full row per beat.
interface weight_streamer_if
    import weight_streamer_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int LANES  = DEF_LANES,
    parameter int AW     = DEF_AW
) ();

    logic                         out_valid;
    logic                         out_ready;
    logic [LANES-1:0][DATA_W-1:0] out_data;
    logic [AW-1:0]                out_row;
    logic                         out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_row,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_row,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/weight_row_ram.sv
// Row-organised weight store: one write port, one registered read port.
// A read and a write to the same row at one edge return the previous contents.
module weight_row_ram #(
    parameter int DATA_W = 32,
    parameter int LANES  = 128,
    parameter int DEPTH  = 912,
    parameter int AW     = $clog2(DEPTH)
) (
    input  logic                         clka,
    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [LANES-1:0][DATA_W-1:0] wr_data,
    input  logic                         rd_en,
    input  logic [AW-1:0]                rd_addr,
    output logic [LANES-1:0][DATA_W-1:0] rd_data
);

    logic [LANES-1:0][DATA_W-1:0] mem [DEPTH];
    logic [LANES-1:0][DATA_W-1:0] rd_data_q;

    // NOTE: the store and its read register carry no reset so they map onto block RAM;
    // the consumer never sees rd_data unless a fetch has completed.
    // NOTE: non-blocking writes mean the read below samples mem before this edge's
    // write lands, which is exactly the read-before-write behaviour wanted.
    always_ff @(posedge clka) begin
        if (wr_en && (int'(wr_addr) < DEPTH)) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/weight_streamer.sv
// Streams one layer's weight rows from the row store to the MAC array on request.
// Holds the run-time layer table, the IDLE/STREAM controller and the row counter.
module weight_streamer
    import weight_streamer_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int LANES      = DEF_LANES,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int NUM_LAYERS = DEF_NUM_LAYERS,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = lw_of(NUM_LAYERS)
) (
    input  logic                         clka,
    input  logic                         rst,

    input  logic                         cfg_we,
    input  logic [LW-1:0]                cfg_layer,
    input  logic [AW-1:0]                cfg_base,
    input  logic [AW:0]                  cfg_len,

    input  logic                         wr_en,
    input  logic [AW-1:0]                wr_addr,
    input  logic [LANES-1:0][DATA_W-1:0] wr_data,

    input  logic                         start,
    input  logic [LW-1:0]                start_layer,
    input  logic                         abort,

    weight_streamer_if.master            stream,

    output logic                         busy,
    output logic                         done,
    output logic                         err
);

    typedef logic [LANES-1:0][DATA_W-1:0] row_w_t;

    typedef struct packed {
        logic [AW-1:0] base;
        logic [AW:0]   len;
    } entry_t;

    state_t        state_q, state_d;
    entry_t        tbl_q [NUM_LAYERS];
    entry_t        tbl_d [NUM_LAYERS];
    logic [AW-1:0] row_q, row_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [AW:0]   len_q, len_d;
    logic          last_q, last_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          rd_en;
    logic [AW-1:0] rd_addr;
    row_w_t        rd_data;

    logic          start_layer_ok;
    logic          cfg_layer_ok;
    entry_t        sel;
    logic [AW-1:0] next_addr;
    logic [AW-1:0] cfg_base_wrapped;

    weight_row_ram #(
        .DATA_W (DATA_W),
        .LANES  (LANES),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clka    (clka),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    assign start_layer_ok   = int'(start_layer) < NUM_LAYERS;
    assign cfg_layer_ok     = int'(cfg_layer) < NUM_LAYERS;
    assign sel              = start_layer_ok ? tbl_q[start_layer] : '0;
    // Store addresses wrap past the top row; a base beyond DEPTH is folded once on entry.
    assign next_addr        = (addr_q == AW'(DEPTH - 1)) ? '0 : addr_q + AW'(1);
    assign cfg_base_wrapped = (int'(cfg_base) >= DEPTH) ? cfg_base - AW'(DEPTH) : cfg_base;

    assign busy = (state_q == STREAM);

    // NOTE: every signal driven here is given a default first, so no path leaves it
    // unassigned and no latch can be inferred.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        addr_d  = addr_q;
        len_d   = len_q;
        last_d  = last_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        rd_en   = 1'b0;
        rd_addr = addr_q;
        tbl_d   = tbl_q;

        // Table writes land at the edge, so a start in the same cycle sees the old entry.
        if (cfg_we) begin
            if (busy || !cfg_layer_ok) begin
                err_d = 1'b1;
            end else begin
                tbl_d[cfg_layer].base = cfg_base_wrapped;
                tbl_d[cfg_layer].len  = cfg_len;
            end
        end

        if (abort) begin
            state_d = IDLE;
            row_d   = '0;
            last_d  = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (!start_layer_ok) begin
                            err_d = 1'b1;
                        end else if (sel.len == '0) begin
                            done_d = 1'b1;
                        end else begin
                            state_d = STREAM;
                            rd_en   = 1'b1;
                            rd_addr = sel.base;
                            addr_d  = sel.base;
                            row_d   = '0;
                            len_d   = sel.len;
                            last_d  = (sel.len == (AW+1)'(1));
                        end
                    end
                end
                STREAM: begin
                    if (start) begin
                        err_d = 1'b1;
                    end
                    // The next row is fetched at the accepting edge, so beats never bubble.
                    if (stream.out_ready) begin
                        if (last_q) begin
                            state_d = IDLE;
                            row_d   = '0;
                            last_d  = 1'b0;
                            done_d  = 1'b1;
                        end else begin
                            rd_en   = 1'b1;
                            rd_addr = next_addr;
                            addr_d  = next_addr;
                            row_d   = row_q + AW'(1);
                            last_d  = (({1'b0, row_q} + (AW+1)'(2)) == len_q);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            row_q   <= '0;
            addr_q  <= '0;
            len_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            for (int i = 0; i < NUM_LAYERS; i++) begin
                tbl_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            last_q  <= last_d;
            done_q  <= done_d;
            err_q   <= err_d;
            tbl_q   <= tbl_d;
        end
    end

    assign stream.out_valid = busy;
    assign stream.out_data  = busy ? rd_data : '0;
    assign stream.out_row   = row_q;
    assign stream.out_last  = last_q;
    assign done             = done_q;
    assign err              = err_q;

endmodule

// File: tb/tb_weight_streamer.sv
// Scoreboard bench for weight_streamer: directed streams push expected beats,
// a negedge monitor pops and compares every accepted row.
module tb_weight_streamer;
    import weight_streamer_pkg::*;

    localparam int DATA_W     = 32;
    localparam int LANES      = 128;
    localparam int DEPTH      = 912;
    localparam int NUM_LAYERS = 3;
    localparam int AW         = $clog2(DEPTH);
    localparam int LW         = $clog2(NUM_LAYERS);
    localparam int TIMEOUT    = 2000;

    typedef struct {
        row_t          data;
        logic [AW-1:0] row;
        logic          last;
    } beat_t;

    logic          clka = 1'b0;
    logic          rst  = 1'b1;
    logic          cfg_we;
    logic [LW-1:0] cfg_layer;
    logic [AW-1:0] cfg_base;
    logic [AW:0]   cfg_len;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    row_t          wr_data;
    logic          start;
    logic [LW-1:0] start_layer;
    logic          abort;
    logic          busy, done, err;

    weight_streamer_if #(.DATA_W(DATA_W), .LANES(LANES), .AW(AW)) s ();

    weight_streamer #(
        .DATA_W     (DATA_W),
        .LANES      (LANES),
        .DEPTH      (DEPTH),
        .NUM_LAYERS (NUM_LAYERS)
    ) dut (
        .clka        (clka),
        .rst         (rst),
        .cfg_we      (cfg_we),
        .cfg_layer   (cfg_layer),
        .cfg_base    (cfg_base),
        .cfg_len     (cfg_len),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .start_layer (start_layer),
        .abort       (abort),
        .stream      (s),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    always #5 clka = ~clka;

    int    checks   = 0;
    int    failures = 0;
    int    done_cnt = 0;
    int    err_cnt  = 0;
    bit    l0_run   = 1'b0;
    beat_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_row(input string name, input row_t act, input row_t exp);
        checks++;
        if (act !== exp) begin
            int lane;
            lane = 0;
            for (int i = LANES - 1; i >= 0; i--) begin
                if (act[i] !== exp[i]) lane = i;
            end
            failures++;
            $display("FAIL %s: lane %0d got 0x%0h expected 0x%0h", name, lane, act[lane], exp[lane]);
        end
    endtask

    // Store row r holds word i = 128*r + i.
    function automatic row_t pat(input int r);
        row_t w;
        for (int i = 0; i < LANES; i++) w[i] = 32'(LANES * r + i);
        return w;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    beat_t         e;
    logic          prev_stall = 1'b0;
    row_t          prev_data;
    logic [AW-1:0] prev_row;
    logic          prev_last;

    always @(negedge clka) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (!s.out_valid) check("out_data_zero_when_invalid", 32'(|s.out_data), 32'd0);
            if (prev_stall && s.out_valid) begin
                check_row("stall_data_stable", s.out_data, prev_data);
                check("stall_row_stable", 32'(s.out_row), 32'(prev_row));
                check("stall_last_stable", 32'(s.out_last), 32'(prev_last));
            end
            if (s.out_valid && s.out_ready) begin
                check("beat_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_row("beat_data", s.out_data, e.data);
                    check("beat_row", 32'(s.out_row), 32'(e.row));
                    check("beat_last", 32'(s.out_last), 32'(e.last));
                end
                if (l0_run && s.out_row == AW'(3)) check("l0_row3_word20", s.out_data[20], 32'd404);
            end
            if (done) done_cnt <= done_cnt + 1;
            if (err)  err_cnt  <= err_cnt + 1;
            prev_stall <= s.out_valid && !s.out_ready;
            prev_data  <= s.out_data;
            prev_row   <= s.out_row;
            prev_last  <= s.out_last;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clka);
        #1;
    endtask

    task automatic write_row(input int a, input row_t d);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic set_cfg(input int l, input int b, input int n);
        cfg_we    = 1'b1;
        cfg_layer = LW'(l);
        cfg_base  = AW'(b);
        cfg_len   = (AW+1)'(n);
        tick();
        cfg_we    = 1'b0;
    endtask

    task automatic push_stream(input int base, input int len);
        for (int r = 0; r < len; r++) begin
            beat_t b;
            b.data = pat((base + r) % DEPTH);
            b.row  = AW'(r);
            b.last = (r == len - 1);
            exp_q.push_back(b);
        end
    endtask

    // Issues start, then counts edges after the sampling edge until done appears.
    task automatic run_stream(input string name, input int layer, input int exp_cycles, input bit toggle);
        int cycles;
        cycles      = 0;
        start       = 1'b1;
        start_layer = LW'(layer);
        s.out_ready = 1'b1;
        tick();
        start = 1'b0;
        check({name, "_busy_after_start"}, 32'(busy), 32'(exp_cycles > 0));
        while (!done && cycles < TIMEOUT) begin
            tick();
            cycles++;
            if (toggle) s.out_ready = ~s.out_ready;
        end
        s.out_ready = 1'b1;
        check({name, "_cycles_to_done"}, 32'(cycles), 32'(exp_cycles));
        tick();
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
        check({name, "_busy_low_after"}, 32'(busy), 32'd0);
        check({name, "_valid_low_after"}, 32'(s.out_valid), 32'd0);
        check({name, "_data_zero_after"}, 32'(|s.out_data), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int   cycles;
        row_t new_row;
        beat_t b;

        cfg_we = 1'b0; cfg_layer = '0; cfg_base = '0; cfg_len = '0;
        wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; start_layer = '0; abort = 1'b0;
        s.out_ready = 1'b0;

        #2;
        check("rst_out_valid", 32'(s.out_valid), 32'd0);
        check("rst_out_data", 32'(|s.out_data), 32'd0);
        check("rst_out_row", 32'(s.out_row), 32'd0);
        check("rst_out_last", 32'(s.out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        tick();
        rst = 1'b0;

        for (int r = 0; r < DEPTH; r++) write_row(r, pat(r));

        // Reset in the middle of a stream clears outputs and the layer table.
        set_cfg(0, 0, 784);
        push_stream(0, 784);
        s.out_ready = 1'b1;
        start = 1'b1; start_layer = '0;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("midrst_row_before", 32'(s.out_row), 32'd5);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(s.out_valid), 32'd0);
        check("midrst_data", 32'(|s.out_data), 32'd0);
        check("midrst_row", 32'(s.out_row), 32'd0);
        check("midrst_last", 32'(s.out_last), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_beats_consumed", 32'(exp_q.size()), 32'd779);
        exp_q.delete();
        #2;
        rst = 1'b0;
        tick();
        run_stream("len0_after_reset", 0, 0, 1'b0);

        // Full layer 0 with the consumer always ready.
        set_cfg(0, 0, 784);
        push_stream(0, 784);
        l0_run = 1'b1;
        run_stream("layer0", 0, 784, 1'b0);
        l0_run = 1'b0;

        // Layer 1 with the consumer stalling every other cycle.
        set_cfg(1, 784, 128);
        push_stream(784, 128);
        run_stream("layer1_toggle", 1, 255, 1'b1);

        // Wrapping layer; rejected requests while busy must not disturb it.
        set_cfg(1, 900, 20);
        push_stream(900, 20);
        s.out_ready = 1'b1;
        start = 1'b1; start_layer = LW'(1);
        tick();
        start = 1'b0;
        tick(); tick();
        start = 1'b1; start_layer = '0;
        tick();
        start = 1'b0;
        check("busy_start_err", 32'(err), 32'd1);
        tick();
        check("busy_start_err_pulse", 32'(err), 32'd0);
        cfg_we = 1'b1; cfg_layer = LW'(1); cfg_base = '0; cfg_len = (AW+1)'(5);
        tick();
        cfg_we = 1'b0;
        check("busy_cfg_err", 32'(err), 32'd1);
        tick();
        check("busy_cfg_err_pulse", 32'(err), 32'd0);
        start = 1'b1; start_layer = LW'(3);
        tick();
        start = 1'b0;
        check("busy_badlayer_err", 32'(err), 32'd1);
        tick();
        check("busy_badlayer_err_pulse", 32'(err), 32'd0);
        cycles = 0;
        while (!done && cycles < TIMEOUT) begin
            tick();
            cycles++;
        end
        check("wrap_err_cycles_to_done", 32'(cycles), 32'd12);
        tick();

        // Same layer again: the rejected table write must have left 900/20 intact.
        push_stream(900, 20);
        run_stream("wrap_clean", 1, 20, 1'b0);

        // Invalid layer from IDLE.
        start = 1'b1; start_layer = LW'(3);
        tick();
        start = 1'b0;
        check("idle_badlayer_err", 32'(err), 32'd1);
        check("idle_badlayer_no_done", 32'(done), 32'd0);
        check("idle_badlayer_not_busy", 32'(busy), 32'd0);
        tick();
        check("idle_badlayer_err_pulse", 32'(err), 32'd0);

        // Abort with a simultaneous start, plus a same-edge write to the row being fetched.
        for (int i = 0; i < LANES; i++) new_row[i] = 32'hA5A5_0000 + 32'(i);
        push_stream(0, 784);
        s.out_ready = 1'b1;
        start = 1'b1; start_layer = '0;
        tick();
        start = 1'b0;
        repeat (9) tick();
        wr_en = 1'b1; wr_addr = AW'(10); wr_data = new_row;
        tick();
        wr_en = 1'b0;
        check("abort_row_before", 32'(s.out_row), 32'd10);
        check_row("row10_read_before_write", s.out_data, pat(10));
        s.out_ready = 1'b0;
        abort = 1'b1; start = 1'b1; start_layer = LW'(1);
        tick();
        abort = 1'b0; start = 1'b0;
        check("abort_valid", 32'(s.out_valid), 32'd0);
        check("abort_data", 32'(|s.out_data), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_no_err", 32'(err), 32'd0);
        check("abort_no_done", 32'(done), 32'd0);
        check("abort_beats_consumed", 32'(exp_q.size()), 32'd774);
        exp_q.delete();
        tick();
        check("abort_no_done_later", 32'(done), 32'd0);
        check("abort_no_err_later", 32'(err), 32'd0);
        check("abort_stays_idle", 32'(s.out_valid), 32'd0);

        // Row 10 now holds the written contents; a one-row layer reads it back.
        set_cfg(2, 10, 1);
        b.data = new_row; b.row = '0; b.last = 1'b1;
        exp_q.push_back(b);
        run_stream("row10_new", 2, 1, 1'b0);

        tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("total_done_pulses", 32'(done_cnt), 32'd6);
        check("total_err_pulses", 32'(err_cnt), 32'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
